time_of_day_counter: RTL and testbench

Timekeeping stage for the starter-board clock design. Divides the 50 MHz board clock into a 1 Hz tick and keeps hours, minutes and seconds (24 h). Two debounced push buttons set the time. Drives the four active-low seven-segment digits HEX3..HEX0 directly, sitting between the board pins (CLOCK_50, KEY, SW) and the HEX outputs of the top level.

---
 rtl/time_of_day_counter_pkg.sv | 45 ++++
 rtl/time_of_day_counter_if.sv | 23 ++
 rtl/time_of_day_counter_debounce.sv | 52 +++++
 rtl/time_of_day_counter_seg.sv | 26 ++
 rtl/time_of_day_counter.sv | 113 +++++++++++
 tb/tb_time_of_day_counter.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/time_of_day_counter_pkg.sv
// Shared constants and types for the 24 h time-of-day counter and its display.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package time_of_day_counter_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int unsigned SECS_PER_MIN  = 60;
   localparam int unsigned MINS_PER_HOUR = 60;
   localparam int unsigned HOURS_PER_DAY = 24;

   typedef enum logic {
      DISP_HHMM = 1'b0,
      DISP_MMSS = 1'b1
   } disp_mode_e;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
   } tod_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   // Two-digit split, valid for v < 60.
   function automatic bcd2_t to_bcd(input logic [5:0] v);
      bcd2_t r;
      r.tens = 4'(v / 6'd10);
      r.ones = 4'(v - 6'({2'b00, r.tens} * 6'd10));
      return r;
   endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Board-side signal bundle of the time-of-day counter: buttons, switch, digits, tick.
interface time_of_day_counter_if;

   logic       INC_HOUR_N;
   logic       INC_MIN_N;
   logic       SHOW_SECONDS;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;
   logic [6:0] HEX3;
   logic       SEC_TICK;

   modport master (
      output INC_HOUR_N, INC_MIN_N, SHOW_SECONDS,
      input  HEX0, HEX1, HEX2, HEX3, SEC_TICK
   );

   modport slave (
      input  INC_HOUR_N, INC_MIN_N, SHOW_SECONDS,
      output HEX0, HEX1, HEX2, HEX3, SEC_TICK
   );

endinterface

// File: rtl/time_of_day_counter_debounce.sv
// Push-button front end: two-flop synchronizer, stability counter, and a
// single-cycle pulse on each accepted press (debounced 1->0).
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic press_o
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          state_q, state_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync2_q != state_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_ni;
         sync2_q <= sync1_q;
         state_q <= state_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/time_of_day_counter_seg.sv
// Combinational 4-bit to active-low seven-segment decoder; codes 10-15 blank.
module seven_seg_decoder
   import time_of_day_counter_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      unique case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/time_of_day_counter.sv
// 24 h time-of-day counter: 1 Hz prescaler, hh:mm:ss registers, button setting
// and a registered four-digit seven-segment display (HH:MM or MM:SS).
module time_of_day_counter
   import time_of_day_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50000000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   time_of_day_counter_if.slave  io
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PW-1:0]      presc_q, presc_d;
   tod_t               tod_q, tod_d;
   logic               tick_q;
   logic [3:0][6:0]    hex_q;

   logic               inc_hour, inc_min;
   logic               tick, sec_last, min_last, min_carry, hour_carry;
   logic [5:0]         hour_sum;
   bcd2_t              hr_bcd, mn_bcd, sc_bcd;
   disp_mode_e         mode;
   logic [3:0][3:0]    dig;
   logic [3:0][6:0]    seg;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hour (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .btn_ni  (io.INC_HOUR_N),
      .press_o (inc_hour)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .btn_ni  (io.INC_MIN_N),
      .press_o (inc_min)
   );

   always_comb begin
      tick       = (presc_q == PW'(CLK_HZ - 1));
      sec_last   = (tod_q.sec == 6'(SECS_PER_MIN - 1));
      min_last   = (tod_q.min == 6'(MINS_PER_HOUR - 1));
      // A minute press replaces the tick for this cycle, so it cannot carry.
      min_carry  = tick & sec_last & ~inc_min;
      hour_carry = min_carry & min_last;

      presc_d = (tick | inc_min) ? '0 : presc_q + PW'(1);

      tod_d = tod_q;
      if (inc_min) begin
         tod_d.sec = '0;
         tod_d.min = min_last ? '0 : tod_q.min + 6'd1;
      end else if (tick) begin
         tod_d.sec = sec_last ? '0 : tod_q.sec + 6'd1;
         if (min_carry) begin
            tod_d.min = min_last ? '0 : tod_q.min + 6'd1;
         end
      end

      // Carry and button may both add one; the sum never exceeds 25.
      hour_sum = {1'b0, tod_q.hour} + {5'b0, hour_carry} + {5'b0, inc_hour};
      if (hour_sum >= 6'(HOURS_PER_DAY)) begin
         tod_d.hour = 5'(hour_sum - 6'(HOURS_PER_DAY));
      end else begin
         tod_d.hour = hour_sum[4:0];
      end
   end

   always_comb begin
      hr_bcd = to_bcd({1'b0, tod_q.hour});
      mn_bcd = to_bcd(tod_q.min);
      sc_bcd = to_bcd(tod_q.sec);
      mode   = disp_mode_e'(io.SHOW_SECONDS);
      dig    = '0;
      unique case (mode)
         DISP_HHMM: dig = {hr_bcd.tens, hr_bcd.ones, mn_bcd.tens, mn_bcd.ones};
         DISP_MMSS: dig = {mn_bcd.tens, mn_bcd.ones, sc_bcd.tens, sc_bcd.ones};
         default:   dig = {hr_bcd.tens, hr_bcd.ones, mn_bcd.tens, mn_bcd.ones};
      endcase
   end

   for (genvar g = 0; g < 4; g++) begin : g_dec
      seven_seg_decoder u_dec (
         .bcd_i (dig[g]),
         .seg_o (seg[g])
      );
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         presc_q <= '0;
         tod_q   <= '0;
         tick_q  <= 1'b0;
         hex_q   <= {4{SEG_0}};
      end else begin
         presc_q <= presc_d;
         tod_q   <= tod_d;
         tick_q  <= tick;
         hex_q   <= seg;
      end
   end

   assign io.HEX0     = hex_q[0];
   assign io.HEX1     = hex_q[1];
   assign io.HEX2     = hex_q[2];
   assign io.HEX3     = hex_q[3];
   assign io.SEC_TICK = tick_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter at CLK_HZ=10, DEBOUNCE_CYCLES=4.
module tb_time_of_day_counter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   time_of_day_counter_if bus ();

   always #5 clk = ~clk;

   time_of_day_counter #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .io       (bus.slave)
   );

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_tick(input string tag, input logic exp);
      n_assert++;
      assert (bus.SEC_TICK === exp) else begin
         n_fail++;
         $error("FAIL %s: observed SEC_TICK=%b, expected %b", tag, bus.SEC_TICK, exp);
      end
   endtask

   task automatic check_disp(input string tag, input int d3, input int d2, input int d1, input int d0);
      check({tag, ".hex3"}, bus.HEX3, seg(d3));
      check({tag, ".hex2"}, bus.HEX2, seg(d2));
      check({tag, ".hex1"}, bus.HEX1, seg(d1));
      check({tag, ".hex0"}, bus.HEX0, seg(d0));
   endtask

   // Advance n clock cycles, leaving time at a falling edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Press is accepted 6 edges after the drive; release settles 6 edges after letting go.
   task automatic press(input bit hour);
      if (hour) bus.INC_HOUR_N = 1'b0;
      else      bus.INC_MIN_N  = 1'b0;
      cyc(8);
      bus.INC_HOUR_N = 1'b1;
      bus.INC_MIN_N  = 1'b1;
      cyc(6);
   endtask

   task automatic presses(input bit hour, input int n);
      repeat (n) press(hour);
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         bit seen = 1'b0;
         for (int i = 0; i < 15 && !seen; i++) begin
            cyc(1);
            if (bus.SEC_TICK === 1'b1) seen = 1'b1;
         end
         n_assert++;
         assert (seen === 1'b1) else begin
            n_fail++;
            $error("FAIL tick_timeout: observed no SEC_TICK in 15 cycles, expected one");
         end
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.INC_HOUR_N   = 1'b1;
      bus.INC_MIN_N    = 1'b1;
      bus.SHOW_SECONDS = 1'b1;

      // Reset state and first ticks.
      cyc(3);
      check_disp("reset", 0, 0, 0, 0);
      check_tick("reset_tick", 1'b0);
      rst_n = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         cyc(1);
         if (k < 10) check_tick($sformatf("pre_tick_%0d", k), 1'b0);
         if (k == 10) begin
            check_tick("first_tick", 1'b1);
            check("first_tick_hex0", bus.HEX0, seg(0));
         end
         if (k == 11) begin
            check_tick("first_tick_end", 1'b0);
            check("sec1_hex0", bus.HEX0, seg(1));
         end
      end
      cyc(9);
      check_tick("second_tick", 1'b1);
      cyc(1);
      check_disp("sec2", 0, 0, 0, 2);

      // Display mux at 13:45:27.
      bus.SHOW_SECONDS = 1'b0;
      presses(1'b1, 13);
      presses(1'b0, 45);
      wait_ticks(27);
      cyc(1);
      check_disp("mux_hhmm", 1, 3, 4, 5);
      bus.SHOW_SECONDS = 1'b1;
      #1;
      check_disp("mux_hold", 1, 3, 4, 5);
      cyc(1);
      check_disp("mux_mmss", 4, 5, 2, 7);

      // Debounce: two 3-cycle bounces are rejected, a long hold counts once.
      bus.INC_MIN_N = 1'b0; cyc(3);
      bus.INC_MIN_N = 1'b1; cyc(1);
      bus.INC_MIN_N = 1'b0; cyc(3);
      bus.INC_MIN_N = 1'b1; cyc(8);
      check("bounce_hex3", bus.HEX3, seg(4));
      check("bounce_hex2", bus.HEX2, seg(5));
      bus.INC_MIN_N = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (i == 7) check_disp("held_min", 4, 6, 0, 0);
         if (i >= 7 && i <= 15) check_tick($sformatf("held_notick_%0d", i), 1'b0);
         if (i == 16) check_tick("held_tick", 1'b1);
      end
      bus.INC_MIN_N = 1'b1;
      cyc(10);
      check("held_once_hex3", bus.HEX3, seg(4));
      check("held_once_hex2", bus.HEX2, seg(6));

      // Day rollover from 23:59:00.
      bus.SHOW_SECONDS = 1'b0;
      presses(1'b1, 10);
      presses(1'b0, 13);
      check_disp("set_2359", 2, 3, 5, 9);
      wait_ticks(60);
      cyc(1);
      check_disp("rollover_hhmm", 0, 0, 0, 0);
      bus.SHOW_SECONDS = 1'b1;
      cyc(1);
      check_disp("rollover_mmss", 0, 0, 0, 0);

      // Hour press coinciding with the carry tick at 00:59:59.
      bus.SHOW_SECONDS = 1'b0;
      presses(1'b0, 59);
      check_disp("set_0059", 0, 0, 5, 9);
      wait_ticks(59);
      cyc(3);
      bus.INC_HOUR_N = 1'b0;
      cyc(8);
      check_disp("hour_with_carry", 0, 2, 0, 0);
      bus.INC_HOUR_N = 1'b1;
      cyc(6);

      // Minute press coinciding with the tick at 00:59:59 suppresses the carry.
      presses(1'b1, 22);
      presses(1'b0, 59);
      check_disp("set_0059b", 0, 0, 5, 9);
      wait_ticks(59);
      cyc(3);
      bus.INC_MIN_N = 1'b0;
      cyc(8);
      check_disp("min_over_tick", 0, 0, 0, 0);
      bus.INC_MIN_N    = 1'b1;
      bus.SHOW_SECONDS = 1'b1;
      cyc(1);
      check_disp("min_over_tick_ss", 0, 0, 0, 0);
      cyc(6);

      // Reset mid-operation at 12:34:56 with the hour button held.
      bus.SHOW_SECONDS = 1'b0;
      presses(1'b1, 12);
      presses(1'b0, 34);
      wait_ticks(56);
      cyc(1);
      bus.SHOW_SECONDS = 1'b1;
      cyc(1);
      check_disp("set_123456_ss", 3, 4, 5, 6);
      bus.SHOW_SECONDS = 1'b0;
      cyc(1);
      check_disp("set_123456_hm", 1, 2, 3, 4);
      bus.INC_HOUR_N = 1'b0;
      rst_n          = 1'b0;
      #1;
      check_disp("async_reset", 0, 0, 0, 0);
      check_tick("async_reset_tick", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 26; i++) begin
         cyc(1);
         if (i <= 6) check($sformatf("held_rst_hex2_%0d", i), bus.HEX2, seg(0));
         if (i == 7) check_disp("held_rst_inc", 0, 1, 0, 0);
         if (i == 25) check_disp("held_rst_once", 0, 1, 0, 0);
      end
      bus.INC_HOUR_N = 1'b1;
      cyc(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
